pe_sel_mux_pipe: RTL and testbench

- Parametrised, pipelined N-way lane selector for the pe_array operand path; successor to the fixed 32x16 combinational selector.
- Selects one WIDTH-bit lane from a flat NUM_IN-lane bus through a two-stage registered mux tree with a valid/ready handshake.
- Lane order is configurable: reversed (legacy) or direct. Out-of-range selects are flagged.
- Sits between the global buffer read bus and the PE operand input registers.

---
 rtl/pe_sel_mux_pipe.sv | 93 +++++++++
 tb/tb_pe_sel_mux_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sel_mux_pipe.sv
// Two-stage pipelined lane selector: stage 1 narrows each GROUP of lanes to one
// candidate, stage 2 picks the candidate group and drives the registered output.
module pe_sel_mux_pipe #(
  parameter int WIDTH   = 16,
  parameter int NUM_IN  = 32,
  parameter int GROUP   = 4,
  parameter int REVERSE = 1,
  parameter int SEL_W   = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH*NUM_IN-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int IDX_W   = SEL_W + 1;
  localparam int GRP_SH  = $clog2(GROUP);
  localparam int NUM_GRP = NUM_IN / GROUP;
  localparam int GRP_W   = IDX_W - GRP_SH;

  logic [IDX_W-1:0]  sel_ext;
  logic [IDX_W-1:0]  idx;
  logic [GRP_SH-1:0] idx_lo;
  logic              oor;
  logic              en;

  logic [WIDTH-1:0]  lane       [NUM_IN];
  logic [WIDTH-1:0]  cand_next  [NUM_GRP];
  logic [WIDTH-1:0]  cand_reg   [NUM_GRP];
  logic [GRP_W-1:0]  grp_reg;
  logic              s1_err_reg;
  logic              s1_valid_reg;
  logic [WIDTH-1:0]  pick;

  // Reversed mapping may wrap for out-of-range selects; oor masks that result.
  assign sel_ext = {1'b0, in_sel};
  assign idx     = (REVERSE != 0) ? (IDX_W'(NUM_IN - 1) - sel_ext) : sel_ext;
  assign idx_lo  = idx[GRP_SH-1:0];
  assign oor     = (sel_ext >= IDX_W'(NUM_IN));

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
      assign lane[gi] = in_data[WIDTH*gi +: WIDTH];
    end
  endgenerate

  always_comb begin
    for (int g = 0; g < NUM_GRP; g++) begin
      cand_next[g] = '0;
      for (int j = 0; j < GROUP; j++) begin
        if (idx_lo == GRP_SH'(j)) cand_next[g] = lane[g*GROUP + j];
      end
    end
  end

  always_comb begin
    pick = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (grp_reg == GRP_W'(g)) pick = cand_reg[g];
    end
  end

  // The whole pipe advances together on en; bubbles are carried, not collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < NUM_GRP; g++) cand_reg[g] <= '0;
      grp_reg      <= '0;
      s1_err_reg   <= 1'b0;
      s1_valid_reg <= 1'b0;
      out_data     <= '0;
      out_err      <= 1'b0;
      out_valid    <= 1'b0;
    end else if (en) begin
      for (int g = 0; g < NUM_GRP; g++) cand_reg[g] <= cand_next[g];
      grp_reg      <= idx[IDX_W-1:GRP_SH];
      s1_err_reg   <= oor;
      s1_valid_reg <= in_valid;
      out_data     <= s1_err_reg ? '0 : pick;
      out_err      <= s1_err_reg;
      out_valid    <= s1_valid_reg;
    end
  end

endmodule

// File: tb/tb_pe_sel_mux_pipe.sv
// Directed bench for pe_sel_mux_pipe: legacy, direct and 24-lane instances share
// one stimulus bus; each task checks the instance relevant to its scenario.
module tb_pe_sel_mux_pipe;

  logic              clk = 1'b0;
  logic              rst;
  logic [16*32-1:0]  in_data;
  logic [4:0]        in_sel;
  logic              in_valid;
  logic              out_ready;

  logic              lg_in_ready, lg_out_err, lg_out_valid;
  logic [15:0]       lg_out_data;
  logic              dr_in_ready, dr_out_err, dr_out_valid;
  logic [15:0]       dr_out_data;
  logic              or_in_ready, or_out_err, or_out_valid;
  logic [15:0]       or_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_sel_mux_pipe dut_lg (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(lg_in_ready), .out_data(lg_out_data), .out_err(lg_out_err),
    .out_valid(lg_out_valid), .out_ready(out_ready)
  );

  pe_sel_mux_pipe #(.REVERSE(0)) dut_dr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(dr_in_ready), .out_data(dr_out_data), .out_err(dr_out_err),
    .out_valid(dr_out_valid), .out_ready(out_ready)
  );

  pe_sel_mux_pipe #(.NUM_IN(24), .GROUP(4), .REVERSE(0)) dut_or (
    .clk(clk), .rst(rst), .in_data(in_data[16*24-1:0]), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(or_in_ready), .out_data(or_out_data),
    .out_err(or_out_err), .out_valid(or_out_valid), .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_sel = 5'd3;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (lg_out_valid !== 1'b0 || lg_out_data !== 16'h0 || lg_out_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: valid=%b data=%h err=%b, want 0/0000/0",
                 c, lg_out_valid, lg_out_data, lg_out_err);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (lg_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", lg_in_ready);
    end
    $display("reset: done");
  endtask

  task automatic test_legacy();
    logic [4:0]  sels [3] = '{5'd31, 5'd0, 5'd5};
    logic [15:0] exps [3] = '{16'h1000, 16'h101F, 16'h101A};
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      in_sel = sels[v]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (lg_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL legacy_latency sel %0d: out_valid=%b after 1 cycle, want 0", sels[v], lg_out_valid);
      end
      tick();
      checks++;
      if (lg_out_valid !== 1'b1 || lg_out_data !== exps[v] || lg_out_err !== 1'b0) begin
        errors++;
        $display("FAIL legacy_data sel %0d: valid=%b data=%h err=%b, want 1/%h/0",
                 sels[v], lg_out_valid, lg_out_data, lg_out_err, exps[v]);
      end
      $display("legacy: sel=%0d out=%h", sels[v], lg_out_data);
      tick();
    end
  endtask

  task automatic test_direct();
    int nvalid = 0;
    out_ready = 1'b1;
    in_sel = 5'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (dr_out_valid !== 1'b1 || dr_out_data !== 16'h1005) begin
      errors++;
      $display("FAIL direct_sel5: valid=%b data=%h, want 1/1005", dr_out_valid, dr_out_data);
    end
    tick();
    for (int i = 0; i <= 32; i++) begin
      in_valid = (i < 32);
      in_sel = 5'(i);
      tick();
      if (dr_out_valid === 1'b1) nvalid++;
      if (i >= 1) begin
        checks++;
        if (dr_out_valid !== 1'b1 || dr_out_data !== 16'h1000 + 16'(i - 1)) begin
          errors++;
          $display("FAIL direct_sweep beat %0d: valid=%b data=%h, want 1/%h",
                   i - 1, dr_out_valid, dr_out_data, 16'h1000 + 16'(i - 1));
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nvalid != 32) begin
      errors++;
      $display("FAIL direct_sweep_count: got %0d valid cycles want 32", nvalid);
    end
    $display("direct: sweep valid cycles=%0d", nvalid);
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          sent = 0;
    int          rcv = 0;
    int          cyc = 0;
    logic        stalled;
    logic [15:0] held;
    while (rcv < 8 && cyc < 80) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      in_sel    = 5'(sent);
      #1;
      checks++;
      if (lg_in_ready !== (!lg_out_valid || out_ready)) begin
        errors++;
        $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, lg_in_ready, !lg_out_valid || out_ready);
      end
      if (lg_out_valid && out_ready) begin
        checks++;
        if (lg_out_data !== 16'h101F - 16'(rcv)) begin
          errors++;
          $display("FAIL bp_data beat %0d: got %h want %h", rcv, lg_out_data, 16'h101F - 16'(rcv));
        end
        $display("backpressure: beat %0d out=%h", rcv, lg_out_data);
        rcv++;
      end
      stalled = lg_out_valid && !out_ready;
      held = lg_out_data;
      if (in_valid && lg_in_ready) sent++;
      tick();
      if (stalled) begin
        checks++;
        if (lg_out_valid !== 1'b1 || lg_out_data !== held) begin
          errors++;
          $display("FAIL bp_stall_hold cyc %0d: valid=%b data=%h want 1/%h", cyc, lg_out_valid, lg_out_data, held);
        end
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (rcv != 8 || sent != 8) begin
      errors++;
      $display("FAIL bp_count: received %0d sent %0d want 8/8", rcv, sent);
    end
    tick();
    tick();
  endtask

  task automatic test_oor();
    logic [4:0]  sels [3] = '{5'd23, 5'd24, 5'd31};
    logic [15:0] exps [3] = '{16'h1017, 16'h0000, 16'h0000};
    logic        errs [3] = '{1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      in_sel = sels[v]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (or_out_valid !== 1'b1 || or_out_data !== exps[v] || or_out_err !== errs[v]) begin
        errors++;
        $display("FAIL oor sel %0d: valid=%b data=%h err=%b, want 1/%h/%b",
                 sels[v], or_out_valid, or_out_data, or_out_err, exps[v], errs[v]);
      end
      $display("oor: sel=%0d out=%h err=%b", sels[v], or_out_data, or_out_err);
      tick();
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    in_sel = 5'd10; in_valid = 1'b1;
    tick();
    in_sel = 5'd11;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if (lg_out_valid !== 1'b1 || lg_out_data !== 16'h1015) begin
      errors++;
      $display("FAIL midrst_stall: valid=%b data=%h want 1/1015", lg_out_valid, lg_out_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    checks++;
    if (lg_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flush: out_valid=%b want 0", lg_out_valid);
    end
    tick();
    checks++;
    if (lg_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stale: out_valid=%b want 0", lg_out_valid);
    end
    in_sel = 5'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (lg_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_latency: out_valid=%b want 0", lg_out_valid);
    end
    tick();
    checks++;
    if (lg_out_valid !== 1'b1 || lg_out_data !== 16'h101D) begin
      errors++;
      $display("FAIL midrst_beat: valid=%b data=%h want 1/101D", lg_out_valid, lg_out_data);
    end
    $display("mid_reset: post-reset beat out=%h", lg_out_data);
    tick();
  endtask

  initial begin
    for (int k = 0; k < 32; k++) in_data[16*k +: 16] = 16'h1000 + 16'(k);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_sel = '0;
    test_reset();
    test_legacy();
    test_direct();
    test_backpressure();
    test_oor();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
